// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: user time-setting controller for the BCD clockwork.
// Captures the running hh:mm:ss, lets the user edit hour/minute/second with
// inc/dec buttons, then commits it through time_set plus a registered time_ow
// strobe held for OW_CYCLES cycles.
// Optional build macro: CLKSET_TIMEOUT_EN adds an idle-abort counter
// (TIMEOUT_CYC cycles without any button press in an edit state).
// Handshake: there is no valid/ready pair here. Buttons are single-cycle pulses
// that are acted on at the clock edge where they are high. time_set is valid
// for the clockwork exactly while time_ow is high.
module clock_set_ctrl #(
    parameter int unsigned OW_CYCLES = 2
`ifdef CLKSET_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 100000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_cancel,
    input  logic [19:0] time_cur,
    output logic [19:0] time_set,
    output logic        time_ow,
    output logic        editing,
    output logic [1:0]  field_sel,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam int OW_W = $clog2(OW_CYCLES) + 1;
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OW_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [19:0]       r_edit;
    logic [19:0]       w_edit_nxt;
    logic              r_time_ow;
    logic [OW_W-1:0]   r_ow_cnt;
    logic              w_edit_st;
    logic              w_any_btn;
    logic              w_step_en;
    logic              w_timeout;
    logic              w_abort;

    // Hour field step (00..23), BCD carry/borrow on the ones digit.
    function automatic logic [5:0] hr_step(input logic [5:0] v, input logic up);
        logic [5:0] r;
        if (up) begin
            if (v >= 6'h23)          r = 6'h00;
            else if (v[3:0] == 4'd9) r = {v[5:4] + 2'd1, 4'd0};
            else                     r = {v[5:4], v[3:0] + 4'd1};
        end else begin
            if (v == 6'h00)          r = 6'h23;
            else if (v[3:0] == 4'd0) r = {v[5:4] - 2'd1, 4'd9};
            else                     r = {v[5:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Minute/second field step (00..59), BCD carry/borrow on the ones digit.
    function automatic logic [6:0] ms_step(input logic [6:0] v, input logic up);
        logic [6:0] r;
        if (up) begin
            if (v >= 7'h59)          r = 7'h00;
            else if (v[3:0] == 4'd9) r = {v[6:4] + 3'd1, 4'd0};
            else                     r = {v[6:4], v[3:0] + 4'd1};
        end else begin
            if (v == 7'h00)          r = 7'h59;
            else if (v[3:0] == 4'd0) r = {v[6:4] - 3'd1, 4'd9};
            else                     r = {v[6:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign w_edit_st = (r_state == ST_SET_H) || (r_state == ST_SET_M) || (r_state == ST_SET_S);
    assign w_any_btn = btn_mode | btn_inc | btn_dec | btn_cancel;
    // inc and dec together cancel each other out
    assign w_step_en = btn_inc ^ btn_dec;

`ifdef CLKSET_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    assign w_timeout = w_edit_st && !w_any_btn && (r_to_cnt == 32'(TIMEOUT_CYC - 1));

    // Idle counter: cleared outside edit and by any button, counts while editing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_to_cnt <= '0;
        else if (!w_edit_st || w_any_btn) r_to_cnt <= '0;
        else                           r_to_cnt <= r_to_cnt + 32'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Cancel (or idle timeout) outranks every other button in edit states
    assign w_abort = btn_cancel | w_timeout;

    // Next state and next edit value; field step is applied before mode advances
    always_comb begin
        w_state_nxt = r_state;
        w_edit_nxt  = r_edit;
        case (r_state)
            ST_IDLE: begin
                if (btn_mode) begin
                    w_state_nxt = ST_SET_H;
                    w_edit_nxt  = time_cur;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (w_step_en) begin
                        if (r_state == ST_SET_H)
                            w_edit_nxt[19:14] = hr_step(r_edit[19:14], btn_inc);
                        else if (r_state == ST_SET_M)
                            w_edit_nxt[13:7] = ms_step(r_edit[13:7], btn_inc);
                        else
                            w_edit_nxt[6:0] = ms_step(r_edit[6:0], btn_inc);
                    end
                    if (btn_mode) begin
                        if (r_state == ST_SET_H)      w_state_nxt = ST_SET_M;
                        else if (r_state == ST_SET_M) w_state_nxt = ST_SET_S;
                        else                          w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (r_ow_cnt == OW_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, edit register, registered overwrite strobe and its length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_edit    <= '0;
            r_time_ow <= 1'b0;
            r_ow_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_edit    <= w_edit_nxt;
            r_time_ow <= (w_state_nxt == ST_COMMIT);
            r_ow_cnt  <= (r_state == ST_COMMIT) ? r_ow_cnt + OW_W'(1) : '0;
        end
    end

    assign time_set  = r_edit;
    assign time_ow   = r_time_ow;
    assign editing   = w_edit_st;
    assign field_sel = (r_state == ST_SET_H) ? 2'd1 :
                       (r_state == ST_SET_M) ? 2'd2 :
                       (r_state == ST_SET_S) ? 2'd3 : 2'd0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed steps, expected committed times kept
// in a queue and popped when the overwrite strobe appears.
module tb_clock_set_ctrl;

    localparam int OW_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        btn_mode, btn_inc, btn_dec, btn_cancel;
    logic [19:0] time_cur;
    logic [19:0] time_set;
    logic        time_ow;
    logic        editing;
    logic [1:0]  field_sel;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];

    clock_set_ctrl #(
        .OW_CYCLES(OW_CYCLES)
`ifdef CLKSET_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(10)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_cancel (btn_cancel),
        .time_cur   (time_cur),
        .time_set   (time_set),
        .time_ow    (time_ow),
        .editing    (editing),
        .field_sel  (field_sel),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] enc(input int h, input int m, input int s);
        logic [5:0] hb;
        logic [6:0] mb;
        logic [6:0] sb;
        hb = {2'(h / 10), 4'(h % 10)};
        mb = {3'(m / 10), 4'(m % 10)};
        sb = {3'(s / 10), 4'(s % 10)};
        return {hb, mb, sb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one-cycle button pulse, outputs sampled 1ns after the edge
    task automatic press(input logic m, input logic i, input logic d, input logic c);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
    endtask

    // one inc/dec on one field of a given start time, checked against a decimal model
    task automatic edit_check(input string tag, input int h, input int m, input int s,
                              input int field, input logic up);
        int nh;
        int nm;
        int ns;
        nh = h; nm = m; ns = s;
        time_cur = enc(h, m, s);
        press(1, 0, 0, 0);
        for (int k = 1; k < field; k++) press(1, 0, 0, 0);
        chk({tag, "_field"}, 32'(field_sel), 32'(field));
        press(0, up, !up, 0);
        if (field == 1)      nh = up ? (h + 1) % 24 : (h + 23) % 24;
        else if (field == 2) nm = up ? (m + 1) % 60 : (m + 59) % 60;
        else                 ns = up ? (s + 1) % 60 : (s + 59) % 60;
        chk(tag, 32'(time_set), 32'(enc(nh, nm, ns)));
        press(0, 0, 0, 1);
        chk({tag, "_cancel"}, 32'(editing), 32'd0);
    endtask

    // scoreboard side: wait for the strobe, pop expected time, measure strobe length
    task automatic commit_check(input string tag);
        int waited;
        int hi;
        logic [19:0] e;
        waited = 0;
        hi = 0;
        while (time_ow !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk({tag, "_ow_seen"}, 32'(time_ow), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
        chk({tag, "_time_set"}, 32'(time_set), 32'(e));
        chk({tag, "_editing"}, 32'(editing), 32'd0);
        while (time_ow === 1'b1 && hi < 20) begin
            hi++;
            // buttons pressed during the strobe must be ignored
            if (hi == 1) press(1, 1, 0, 0);
            else         tick();
            if (time_ow === 1'b1) chk({tag, "_stable"}, 32'(time_set), 32'(e));
        end
        chk({tag, "_ow_len"}, 32'(hi), 32'(OW_CYCLES));
        chk({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
        chk({tag, "_edit_off"}, 32'(editing), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
        time_cur = enc(12, 34, 56);
        repeat (3) tick();
        chk("rst_time_set", 32'(time_set), 32'd0);
        chk("rst_time_ow", 32'(time_ow), 32'd0);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_field", 32'(field_sel), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_state", 32'(dbg_state), 32'd0);

        // main sequence: 12:34:56 -> 14:33:56
        press(1, 0, 0, 0);
        chk("seq_capture", 32'(time_set), 32'(enc(12, 34, 56)));
        chk("seq_editing", 32'(editing), 32'd1);
        chk("seq_field_h", 32'(field_sel), 32'd1);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        chk("seq_hour", 32'(time_set), 32'(enc(14, 34, 56)));
        press(1, 0, 0, 0);
        chk("seq_field_m", 32'(field_sel), 32'd2);
        press(0, 0, 1, 0);
        chk("seq_min", 32'(time_set), 32'(enc(14, 33, 56)));
        press(1, 0, 0, 0);
        chk("seq_field_s", 32'(field_sel), 32'd3);
        exp_q.push_back(enc(14, 33, 56));
        press(1, 0, 0, 0);
        commit_check("seq");

        // hour boundaries
        edit_check("hr_23_inc", 23, 0, 0, 1, 1'b1);
        edit_check("hr_00_dec", 0, 0, 0, 1, 1'b0);
        edit_check("hr_09_inc", 9, 15, 0, 1, 1'b1);
        edit_check("hr_20_dec", 20, 15, 0, 1, 1'b0);
        // minute / second boundaries
        edit_check("mn_59_inc", 10, 59, 7, 2, 1'b1);
        edit_check("mn_00_dec", 10, 0, 7, 2, 1'b0);
        edit_check("mn_39_inc", 10, 39, 7, 2, 1'b1);
        edit_check("sc_59_inc", 10, 7, 59, 3, 1'b1);
        edit_check("sc_00_dec", 10, 7, 0, 3, 1'b0);
        edit_check("sc_39_inc", 10, 7, 39, 3, 1'b1);

        // inc+dec together: no change
        time_cur = enc(5, 42, 18);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 1, 1, 0);
        chk("incdec_same", 32'(time_set), 32'(enc(5, 42, 18)));
        // cancel outranks inc and mode
        press(1, 1, 0, 1);
        chk("cancel_prio_val", 32'(time_set), 32'(enc(5, 42, 18)));
        chk("cancel_prio_state", 32'(dbg_state), 32'd0);

        // cancel in SET_M after edits: back to idle, no strobe, value held
        time_cur = enc(12, 34, 56);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        chk("cancel_editing", 32'(editing), 32'd0);
        chk("cancel_field", 32'(field_sel), 32'd0);
        chk("cancel_hold", 32'(time_set), 32'(enc(13, 33, 56)));
        for (int k = 0; k < 5; k++) begin
            chk("cancel_no_ow", 32'(time_ow), 32'd0);
            tick();
        end

        // mode+inc in the same cycle on SET_S: 23:59:59 -> 23:59:00 committed
        time_cur = enc(23, 59, 59);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        exp_q.push_back(enc(23, 59, 0));
        press(1, 1, 0, 0);
        commit_check("modeinc");

        // reset during the first commit cycle
        time_cur = enc(1, 2, 3);
        repeat (4) press(1, 0, 0, 0);
        chk("rstc_ow_before", 32'(time_ow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstc_ow_drop", 32'(time_ow), 32'd0);
        chk("rstc_time_set", 32'(time_set), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstc_state", 32'(dbg_state), 32'd0);
        chk("rstc_outs", 32'({time_set, time_ow, editing, field_sel}), 32'd0);

`ifdef CLKSET_TIMEOUT_EN
        // idle timeout in SET_S after 10 cycles
        time_cur = enc(8, 8, 8);
        repeat (3) press(1, 0, 0, 0);
        repeat (9) tick();
        chk("to_still_edit", 32'(editing), 32'd1);
        tick();
        chk("to_abort", 32'(editing), 32'd0);
        chk("to_no_ow", 32'(time_ow), 32'd0);
        // inc at cycle 8 restarts the count
        repeat (3) press(1, 0, 0, 0);
        repeat (7) tick();
        press(0, 1, 0, 0);
        repeat (9) tick();
        chk("to_restart_edit", 32'(editing), 32'd1);
        tick();
        chk("to_restart_abort", 32'(editing), 32'd0);
        chk("to_restart_no_ow", 32'(time_ow), 32'd0);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
